// File: rtl/sv39_ptw.sv
// sv39_ptw -- single-walker Sv39 page-table walker.
//
// Translates one 64-bit virtual address at a time. Bare mode (satp_mode != 8)
// and M-mode (priv_mode == 3) pass the address straight through. Otherwise the
// walker reads up to three PTEs, one per level (2, 1, 0), and returns either a
// physical address or a page fault.
//
// Ports:
//   clk, reset        : clock (rising edge) and asynchronous active-low reset
//   satp_mode/ppn     : translation mode (8 = Sv39) and root page-table PPN
//   priv_mode         : current privilege level (3 = M-mode)
//   vreq_valid/addr   : translation request, held until done
//   flush             : sfence / satp-write pulse
//   done/paddr/page_fault : one-cycle result strobe and its payload
//   mem_valid/addr    : PTE read request, held until mem_ok
//   mem_ok/mem_data   : PTE read response
//
// Optional feature: define PTW_TLB_EN to add a 1-entry translation cache.
// The cache is filled by every successful walk and cleared by flush or reset.
//
// PA_WIDTH must not exceed 64.

module sv39_ptw #(
  parameter int PA_WIDTH = 56
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          satp_mode,
  input  logic [43:0]         satp_ppn,
  input  logic [1:0]          priv_mode,
  input  logic                vreq_valid,
  input  logic [63:0]         vreq_addr,
  input  logic                flush,
  output logic                done,
  output logic [PA_WIDTH-1:0] paddr,
  output logic                page_fault,
  output logic                mem_valid,
  output logic [PA_WIDTH-1:0] mem_addr,
  input  logic                mem_ok,
  input  logic [63:0]         mem_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_e;

  // Replace the low 9*level PPN bits with VPN bits (superpage translation).
  function automatic logic [43:0] merge_ppn(input logic [43:0] ppn,
                                            input logic [26:0] vpn,
                                            input logic [1:0]  level);
    logic [43:0] r;
    r = ppn;
    case (level)
      2'd2:    r[17:0] = vpn[17:0];
      2'd1:    r[8:0]  = vpn[8:0];
      default: r       = ppn;
    endcase
    return r;
  endfunction

  // Select the 9-bit VPN field that indexes the table at a given level.
  function automatic logic [8:0] vpn_idx(input logic [26:0] vpn,
                                         input logic [1:0]  level);
    logic [8:0] r;
    case (level)
      2'd2:    r = vpn[26:18];
      2'd1:    r = vpn[17:9];
      default: r = vpn[8:0];
    endcase
    return r;
  endfunction

  // PTE address: table base page plus 8 bytes per entry.
  function automatic logic [63:0] pte_addr(input logic [43:0] base,
                                           input logic [8:0]  idx);
    return {8'd0, base, 12'd0} + {52'd0, idx, 3'd0};
  endfunction

  state_e                state_q, state_d;
  logic [1:0]            level_q, level_d;
  logic [43:0]           base_q, base_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  done_q, done_d;
  logic                  page_fault_q, page_fault_d;
  logic [PA_WIDTH-1:0]   paddr_q, paddr_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [PA_WIDTH-1:0]   mem_addr_q, mem_addr_d;

  logic                  sv39_s;
  logic                  canonical_s;
  logic [26:0]           vpn_s;
  logic [43:0]           pte_ppn_s;
  logic                  pte_v_s, pte_r_s, pte_w_s, pte_x_s;
  logic                  pte_leaf_s;
  logic                  pte_misaligned_s;
  logic                  pte_bad_s;
  logic                  leaf_ok_s;
  logic [1:0]            next_level_s;
  logic [63:0]           root_addr_s;
  logic [63:0]           next_addr_s;
  logic [63:0]           leaf_pa_s;
  logic                  tlb_hit_s;
  logic [63:0]           tlb_pa_s;
  logic                  unused_s;

  // RSW, D, A, G, U and the reserved top bits of a PTE are deliberately ignored.
  assign unused_s = ^{mem_data[63:54], mem_data[9:4]};

  // Request decode and PTE field extraction.
  always_comb begin
    sv39_s           = (satp_mode == 4'd8) && (priv_mode != 2'd3);
    canonical_s      = (vreq_addr[63:39] == {25{vreq_addr[38]}});
    vpn_s            = vreq_addr[38:12];
    pte_ppn_s        = mem_data[53:10];
    pte_v_s          = mem_data[0];
    pte_r_s          = mem_data[1];
    pte_w_s          = mem_data[2];
    pte_x_s          = mem_data[3];
    pte_leaf_s       = pte_r_s || pte_x_s;
    // A superpage leaf must have zero in the PPN fields it replaces.
    case (level_q)
      2'd2:    pte_misaligned_s = (pte_ppn_s[17:0] != 18'd0);
      2'd1:    pte_misaligned_s = (pte_ppn_s[8:0] != 9'd0);
      default: pte_misaligned_s = 1'b0;
    endcase
    pte_bad_s        = !pte_v_s || (!pte_r_s && pte_w_s) ||
                       (pte_leaf_s && pte_misaligned_s);
    // A good leaf returned for a walk that has not been flushed.
    leaf_ok_s        = (state_q == WALK) && mem_ok && !flush_pend_q && !flush &&
                       !pte_bad_s && pte_leaf_s;
    next_level_s     = level_q - 2'd1;
    root_addr_s      = pte_addr(satp_ppn, vpn_s[26:18]);
    next_addr_s      = pte_addr(pte_ppn_s, vpn_idx(vpn_s, next_level_s));
    leaf_pa_s        = {8'd0, merge_ppn(pte_ppn_s, vpn_s, level_q), vreq_addr[11:0]};
  end

`ifdef PTW_TLB_EN
  logic        tlb_valid_q, tlb_valid_d;
  logic [26:0] tlb_vpn_q, tlb_vpn_d;
  logic [43:0] tlb_ppn_q, tlb_ppn_d;
  logic [1:0]  tlb_level_q, tlb_level_d;

  // Cache lookup against the current request.
  always_comb begin
    tlb_hit_s = tlb_valid_q && (tlb_vpn_q == vpn_s);
    tlb_pa_s  = {8'd0, merge_ppn(tlb_ppn_q, vpn_s, tlb_level_q), vreq_addr[11:0]};
  end

  // Cache update: flush clears, a successful walk fills.
  always_comb begin
    tlb_valid_d = tlb_valid_q;
    tlb_vpn_d   = tlb_vpn_q;
    tlb_ppn_d   = tlb_ppn_q;
    tlb_level_d = tlb_level_q;
    if (flush) begin
      tlb_valid_d = 1'b0;
    end else if (leaf_ok_s) begin
      tlb_valid_d = 1'b1;
      tlb_vpn_d   = vpn_s;
      tlb_ppn_d   = pte_ppn_s;
      tlb_level_d = level_q;
    end else begin
      tlb_valid_d = tlb_valid_q;
    end
  end

  // Cache registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tlb_valid_q <= 1'b0;
      tlb_vpn_q   <= 27'd0;
      tlb_ppn_q   <= 44'd0;
      tlb_level_q <= 2'd0;
    end else begin
      tlb_valid_q <= tlb_valid_d;
      tlb_vpn_q   <= tlb_vpn_d;
      tlb_ppn_q   <= tlb_ppn_d;
      tlb_level_q <= tlb_level_d;
    end
  end
`else
  assign tlb_hit_s = 1'b0;
  assign tlb_pa_s  = 64'd0;
`endif

  // Walk FSM: next state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    base_d       = base_q;
    flush_pend_d = flush_pend_q;
    done_d       = 1'b0;
    page_fault_d = 1'b0;
    paddr_d      = paddr_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (vreq_valid) begin
          if (!sv39_s) begin
            state_d = DONE;
            done_d  = 1'b1;
            paddr_d = vreq_addr[PA_WIDTH-1:0];
          end else if (!canonical_s) begin
            state_d      = DONE;
            done_d       = 1'b1;
            page_fault_d = 1'b1;
            paddr_d      = {PA_WIDTH{1'b0}};
          end else if (tlb_hit_s) begin
            state_d = DONE;
            done_d  = 1'b1;
            paddr_d = tlb_pa_s[PA_WIDTH-1:0];
          end else begin
            state_d     = WALK;
            level_d     = 2'd2;
            base_d      = satp_ppn;
            mem_valid_d = 1'b1;
            mem_addr_d  = root_addr_s[PA_WIDTH-1:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
      WALK: begin
        // A flush cannot cancel a read already on the bus; remember it instead.
        if (flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (mem_ok) begin
          mem_valid_d = 1'b0;
          if (flush_pend_q || flush) begin
            state_d = IDLE;
            level_d = 2'd2;
          end else if (pte_bad_s) begin
            state_d      = DONE;
            level_d      = 2'd2;
            done_d       = 1'b1;
            page_fault_d = 1'b1;
            paddr_d      = {PA_WIDTH{1'b0}};
          end else if (leaf_ok_s) begin
            state_d = DONE;
            level_d = 2'd2;
            done_d  = 1'b1;
            paddr_d = leaf_pa_s[PA_WIDTH-1:0];
          end else if (level_q == 2'd0) begin
            state_d      = DONE;
            level_d      = 2'd2;
            done_d       = 1'b1;
            page_fault_d = 1'b1;
            paddr_d      = {PA_WIDTH{1'b0}};
          end else begin
            level_d     = next_level_s;
            base_d      = pte_ppn_s;
            mem_valid_d = 1'b1;
            mem_addr_d  = next_addr_s[PA_WIDTH-1:0];
          end
        end else begin
          state_d = WALK;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        level_d     = 2'd2;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      level_q      <= 2'd2;
      base_q       <= 44'd0;
      flush_pend_q <= 1'b0;
      done_q       <= 1'b0;
      page_fault_q <= 1'b0;
      paddr_q      <= {PA_WIDTH{1'b0}};
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= {PA_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      base_q       <= base_d;
      flush_pend_q <= flush_pend_d;
      done_q       <= done_d;
      page_fault_q <= page_fault_d;
      paddr_q      <= paddr_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign done       = done_q;
  assign page_fault = page_fault_q;
  assign paddr      = paddr_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_sv39_ptw.sv
// tb_sv39_ptw -- directed self-checking bench for sv39_ptw.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Build with PTW_TLB_EN defined to exercise the translation cache.

module tb_sv39_ptw;

  localparam int PA_W = 56;
  localparam logic [9:0] NL   = 10'h001;  // valid non-leaf
  localparam logic [9:0] LEAF = 10'h00F;  // valid leaf, R/W/X

  logic            clk;
  logic            reset;
  logic [3:0]      satp_mode;
  logic [43:0]     satp_ppn;
  logic [1:0]      priv_mode;
  logic            vreq_valid;
  logic [63:0]     vreq_addr;
  logic            flush;
  logic            done;
  logic [PA_W-1:0] paddr;
  logic            page_fault;
  logic            mem_valid;
  logic [PA_W-1:0] mem_addr;
  logic            mem_ok;
  logic [63:0]     mem_data;

  int n_checks = 0;
  int n_errors = 0;

  sv39_ptw #(.PA_WIDTH(PA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .satp_mode  (satp_mode),
    .satp_ppn   (satp_ppn),
    .priv_mode  (priv_mode),
    .vreq_valid (vreq_valid),
    .vreq_addr  (vreq_addr),
    .flush      (flush),
    .done       (done),
    .paddr      (paddr),
    .page_fault (page_fault),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_ok     (mem_ok),
    .mem_data   (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pte(input logic [43:0] ppn, input logic [9:0] flags);
    return {10'd0, ppn, flags};
  endfunction

  // Optionally flush (idle, no FSM effect) then raise a request for one edge.
  task automatic start_req(input logic [63:0] addr, input logic do_flush);
    if (do_flush) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    vreq_addr  = addr;
    vreq_valid = 1'b1;
    tick();
  endtask

  // Expect a pending PTE read at exp_addr, then answer it.
  task automatic pte_read(input string tag, input logic [63:0] exp_addr, input logic [63:0] data);
    check({tag, "_mem_valid"}, {63'd0, mem_valid}, 64'd1);
    check({tag, "_mem_addr"}, {8'd0, mem_addr}, exp_addr);
    check({tag, "_no_done"}, {63'd0, done}, 64'd0);
    mem_ok   = 1'b1;
    mem_data = data;
    tick();
    mem_ok   = 1'b0;
    mem_data = 64'd0;
  endtask

  // Expect the done strobe now, then drop the request and see it end.
  task automatic finish_req(input string tag, input logic exp_pf,
                            input logic [63:0] exp_pa, input logic chk_pa);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_fault"}, {63'd0, page_fault}, {63'd0, exp_pf});
    check({tag, "_no_mem"}, {63'd0, mem_valid}, 64'd0);
    if (chk_pa) begin
      check({tag, "_paddr"}, {8'd0, paddr}, exp_pa);
    end else begin
      check({tag, "_paddr_zero"}, {8'd0, paddr}, 64'd0);
    end
    vreq_valid = 1'b0;
    tick();
    check({tag, "_done_1cyc"}, {63'd0, done}, 64'd0);
  endtask

  // Three-level walk of 0x4000_0123 under root 0x80000.
  task automatic walk038(input string tag, input logic do_flush);
    satp_mode = 4'd8;
    priv_mode = 2'd0;
    satp_ppn  = 44'h80000;
    start_req(64'h4000_0123, do_flush);
    pte_read({tag, "_l2"}, 64'h8000_0008, pte(44'h80001, NL));
    pte_read({tag, "_l1"}, 64'h8000_1000, pte(44'h80002, NL));
    pte_read({tag, "_l0"}, 64'h8000_2000, pte(44'h80123, LEAF));
    finish_req(tag, 1'b0, 64'h8012_3123, 1'b1);
  endtask

  initial begin
    reset      = 1'b0;
    satp_mode  = 4'd0;
    satp_ppn   = 44'd0;
    priv_mode  = 2'd0;
    vreq_valid = 1'b0;
    vreq_addr  = 64'd0;
    flush      = 1'b0;
    mem_ok     = 1'b0;
    mem_data   = 64'd0;
    #2;
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_fault", {63'd0, page_fault}, 64'd0);
    check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_paddr", {8'd0, paddr}, 64'd0);
    check("rst_mem_addr", {8'd0, mem_addr}, 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Bare mode pass-through.
    start_req(64'h8000_1234, 1'b0);
    finish_req("bare", 1'b0, 64'h8000_1234, 1'b1);

    // M-mode bypass, address truncated to 56 bits.
    satp_mode = 4'd8;
    priv_mode = 2'd3;
    start_req(64'hFF12_3456_789A_BCDE, 1'b0);
    finish_req("mmode", 1'b0, 64'h0012_3456_789A_BCDE, 1'b1);
    priv_mode = 2'd0;

    // Non-canonical address faults without a read.
    satp_ppn = 44'h80000;
    start_req(64'h0000_0080_0000_0000, 1'b1);
    finish_req("noncanon", 1'b1, 64'd0, 1'b0);

    // Valid gigapage, with the read left pending one extra cycle.
    start_req(64'h4012_3456, 1'b1);
    tick();
    pte_read("giga", 64'h8000_0008, pte(44'hC0000, 10'h003));
    finish_req("giga", 1'b0, 64'hC012_3456, 1'b1);

    // Misaligned gigapage.
    start_req(64'h4000_0123, 1'b1);
    pte_read("misal", 64'h8000_0008, pte(44'h40001, LEAF));
    finish_req("misal", 1'b1, 64'd0, 1'b0);

    // Write-only PTE at level 2.
    start_req(64'h4000_0123, 1'b1);
    pte_read("wonly", 64'h8000_0008, pte(44'h80001, 10'h005));
    finish_req("wonly", 1'b1, 64'd0, 1'b0);

    // Negative canonical address, invalid PTE at level 1.
    start_req(64'hFFFF_FFC0_0000_0000, 1'b1);
    pte_read("neg_l2", 64'h8000_0800, pte(44'h80001, NL));
    pte_read("neg_l1", 64'h8000_1000, pte(44'h80002, 10'h000));
    finish_req("neg_inv", 1'b1, 64'd0, 1'b0);

    // Non-leaf at level 0.
    start_req(64'h4000_0123, 1'b1);
    pte_read("nl0_l2", 64'h8000_0008, pte(44'h80001, NL));
    pte_read("nl0_l1", 64'h8000_1000, pte(44'h80002, NL));
    pte_read("nl0_l0", 64'h8000_2000, pte(44'h80003, NL));
    finish_req("nl0", 1'b1, 64'd0, 1'b0);

    // Flush while the level-1 read is pending.
    start_req(64'h4000_0123, 1'b1);
    pte_read("fl_l2", 64'h8000_0008, pte(44'h80001, NL));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    check("fl_held_valid", {63'd0, mem_valid}, 64'd1);
    check("fl_held_addr", {8'd0, mem_addr}, 64'h8000_1000);
    mem_ok   = 1'b1;
    mem_data = pte(44'h80002, NL);
    tick();
    mem_ok   = 1'b0;
    mem_data = 64'd0;
    check("fl_no_done", {63'd0, done}, 64'd0);
    check("fl_no_mem", {63'd0, mem_valid}, 64'd0);
    vreq_valid = 1'b0;
    tick();
    check("fl_still_no_done", {63'd0, done}, 64'd0);
    satp_mode = 4'd0;
    start_req(64'h0000_0000_1111_2222, 1'b0);
    finish_req("fl_idle", 1'b0, 64'h1111_2222, 1'b1);

    // Reset asserted mid-walk.
    satp_mode = 4'd8;
    start_req(64'h4000_0123, 1'b1);
    check("rw_mem_valid", {63'd0, mem_valid}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rw_async_valid", {63'd0, mem_valid}, 64'd0);
    check("rw_async_addr", {8'd0, mem_addr}, 64'd0);
    vreq_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rw_after_done", {63'd0, done}, 64'd0);
    check("rw_after_mem", {63'd0, mem_valid}, 64'd0);

    // Full walk, then a repeat of the same request.
    walk038("walk", 1'b1);
`ifdef PTW_TLB_EN
    start_req(64'h4000_0123, 1'b0);
    finish_req("tlb_hit", 1'b0, 64'h8012_3123, 1'b1);
    walk038("tlb_after_flush", 1'b1);
`else
    walk038("walk_again", 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
